puf_authenticator: RTL
======================

PUF_AUTHENTICATOR -- requirements
Module: puf_authenticator

Interface
REQ-001 SHALL have parameter THRESHOLD, default 1, max Hamming distance over RESPONSE[7:1] accepted as a pass.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1048576, count_clk cycles allowed for the PUF to return DONE high.
REQ-003 count_clk  input  1  block clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  single-cycle request; sampled only in IDLE.
REQ-006 enroll  input  1  with start: 1 = enroll, 0 = verify.
REQ-007 chal_in  input  6  challenge index selecting RO configuration and enrollment slot.
REQ-008 puf_challenge  output  8  drives the PUF CHALLENGE input.
REQ-009 puf_response  input  8  PUF RESPONSE; bit 0 is undriven and SHALL be ignored.
REQ-010 puf_done  input  1  PUF DONE.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 result_valid  output  1  one-cycle pulse when an operation ends.
REQ-013 pass  output  1  verify outcome; valid with result_valid.
REQ-014 timeout  output  1  operation aborted on timeout; valid with result_valid.
REQ-015 hdist  output  3  popcount of (measured XOR enrolled) over bits [7:1]; valid with result_valid.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, EVAL, REPORT.
REQ-017 IDLE -> ISSUE on start=1; latch enroll and chal_in.
REQ-018 ISSUE (1 cycle): drive puf_challenge = {p, 1'b0, chal}, with p chosen so ^puf_challenge differs from the previously driven parity; then go to WAIT_LOW.
REQ-019 puf_challenge SHALL hold its value from ISSUE until the next ISSUE.
REQ-020 WAIT_LOW: wait for puf_done=0; if puf_done is not 0 within 4 cycles, go to REPORT with timeout=1.
REQ-021 WAIT_HIGH: wait for puf_done=1, then capture puf_response & 8'hFE and go to EVAL; if the cycle counter reaches TIMEOUT_CYC, go to REPORT with timeout=1.
REQ-022 Timeout counter: 21-bit, cleared in ISSUE, saturates at its maximum.
REQ-023 EVAL, enroll: write the captured value to slot chal of a 64x8 table, set valid[chal], pass=1, hdist=0.
REQ-024 EVAL, verify: if valid[chal]=0 then pass=0 and hdist=7; otherwise hdist = popcount and pass = (hdist <= THRESHOLD).
REQ-025 REPORT: pulse result_valid for 1 cycle, return to IDLE; pass/hdist/timeout hold until the next REPORT.
REQ-026 On timeout: pass=0, table unchanged.
REQ-027 start while busy=1 SHALL be ignored, not queued.
REQ-028 Latency, start to result_valid: measured PUF time + 4 cycles (ISSUE, WAIT_LOW exit, EVAL, REPORT).

Reset
REQ-029 Reset SHALL force IDLE, busy=0, result_valid=0, pass=0, timeout=0, hdist=0, puf_challenge=8'h00, stored parity=0, all valid bits=0.
REQ-030 Table data SHALL NOT be reset.
REQ-031 Reset mid-operation SHALL abandon the operation without writing the table or emitting result_valid.

Configuration
REQ-032 Macro PUF_AUTH_MAJORITY_EN.
REQ-033 Defined: enrollment runs ISSUE..WAIT_HIGH three times (parity toggled each time) and stores the bitwise majority; a timeout on any run aborts the enrollment.
REQ-034 Undefined: a single measurement is stored.
REQ-035 Verify behaviour SHALL be identical with or without the macro.

Structure
REQ-036 Package puf_auth_pkg SHALL hold the state enum, the 8'hFE response mask, and the popcount7 function.
REQ-037 Sub-module puf_enroll_mem: 64x8 synchronous-write, asynchronous-read table plus its valid bits.

Verification
REQ-038 Reset, then enroll chal=6'h05 with the model returning 8'hA5 -> puf_challenge=8'h85 (parity 1), result_valid, pass=1, slot 5 holds 8'hA4.
REQ-039 Verify chal=5 with model 8'hA6 -> hdist=1, pass=1 (THRESHOLD=1); with model 8'h5B -> hdist=7, pass=0.
REQ-040 Verify chal=6'h3F with slot empty -> pass=0, hdist=7, timeout=0.
REQ-041 Model holds puf_done=1 after ISSUE -> timeout=1 after 4 cycles; model never raises DONE -> timeout=1 at TIMEOUT_CYC.
REQ-042 Two back-to-back operations on the same chal -> driven parity alternates; start pulsed while busy -> ignored.
REQ-043 With PUF_AUTH_MAJORITY_EN, runs returning 8'hF0, 8'hF2, 8'h02 -> stored 8'hF2; reset asserted during the second run -> slot unchanged, no result_valid.

Source files
------------

// File: rtl/puf_auth_pkg.sv
// Shared types, widths and helpers for the PUF authenticator.
package puf_auth_pkg;

  localparam int unsigned CHAL_W    = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TBL_DEPTH = 64;
  localparam int unsigned CNT_W     = 21;

  // Response bit 0 is not driven by the PUF and is always discarded.
  localparam logic [DATA_W-1:0] RESP_MASK = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_EVAL,
    ST_REPORT
  } state_t;

  // Number of set bits in a 7-bit vector.
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/puf_enroll_mem.sv
// Enrollment table: 64 x 8 synchronous-write, asynchronous-read, plus
// per-slot valid bits. Only the valid bits are cleared by reset.
module puf_enroll_mem
  import puf_auth_pkg::*;
(
  input  logic              count_clk,
  input  logic              reset,
  input  logic              we,
  input  logic [CHAL_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic              rvalid_c
);

  logic [DATA_W-1:0]    mem_q [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] valid_q;

  // Table data write; deliberately not reset.
  always_ff @(posedge count_clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Valid bit tracking; reset empties the whole table logically.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[addr] <= 1'b1;
    end
  end

  assign rdata_c  = mem_q[addr];
  assign rvalid_c = valid_q[addr];

endmodule

// File: rtl/puf_authenticator.sv
// PUF authenticator: issues a challenge, waits for the PUF handshake,
// then enrolls or verifies the response against a 64-entry table.
// Optional feature macro: PUF_AUTH_MAJORITY_EN (enroll stores the bitwise
// majority of three measurements instead of a single one).
module puf_authenticator
  import puf_auth_pkg::*;
#(
  parameter int unsigned THRESHOLD   = 1,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic              count_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enroll,
  input  logic [CHAL_W-1:0] chal_in,
  output logic [DATA_W-1:0] puf_challenge,
  input  logic [DATA_W-1:0] puf_response,
  input  logic              puf_done,
  output logic              busy,
  output logic              result_valid,
  output logic              pass,
  output logic              timeout,
  output logic [2:0]        hdist
);

  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(3);

  state_t            state_q;
  logic              enroll_q;
  logic [CHAL_W-1:0] chal_q;
  logic              parity_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] meas_q;
`ifdef PUF_AUTH_MAJORITY_EN
  logic [1:0]        run_q;
  logic [DATA_W-1:0] m0_q;
  logic [DATA_W-1:0] m1_q;
`endif

  logic [CHAL_W-1:0] chal_sel_c;
  logic [DATA_W-1:0] issue_chal_c;
  logic [DATA_W-1:0] cap_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic              mem_rvalid_c;
  logic [DATA_W-1:0] diff_c;
  logic [2:0]        hd_c;

  // Top bit picked so every issued challenge flips the overall parity.
  assign chal_sel_c   = (state_q == ST_IDLE) ? chal_in : chal_q;
  assign issue_chal_c = {(~parity_q) ^ (^chal_sel_c), 1'b0, chal_sel_c};
  assign cap_c        = puf_response & RESP_MASK;
  assign cnt_inc_c    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign mem_we_c     = (state_q == ST_EVAL) && enroll_q;
  assign diff_c       = meas_q ^ mem_rdata_c;
  assign hd_c         = popcount7(7'(diff_c >> 1));

  puf_enroll_mem u_mem (
    .count_clk (count_clk),
    .reset     (reset),
    .we        (mem_we_c),
    .addr      (chal_q),
    .wdata     (meas_q),
    .rdata_c   (mem_rdata_c),
    .rvalid_c  (mem_rvalid_c)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      enroll_q      <= 1'b0;
      chal_q        <= '0;
      parity_q      <= 1'b0;
      cnt_q         <= '0;
      meas_q        <= '0;
      puf_challenge <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      hdist         <= '0;
`ifdef PUF_AUTH_MAJORITY_EN
      run_q         <= '0;
      m0_q          <= '0;
      m1_q          <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            enroll_q      <= enroll;
            chal_q        <= chal_in;
            puf_challenge <= issue_chal_c;
            parity_q      <= ~parity_q;
            busy          <= 1'b1;
            state_q       <= ST_ISSUE;
`ifdef PUF_AUTH_MAJORITY_EN
            run_q         <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          cnt_q <= cnt_inc_c;
          if (!puf_done) begin
            state_q <= ST_WAIT_HIGH;
          end else if (cnt_q == LOW_LAST) begin
            result_valid <= 1'b1;
            timeout      <= 1'b1;
            pass         <= 1'b0;
            hdist        <= '0;
            state_q      <= ST_REPORT;
          end
        end
        ST_WAIT_HIGH: begin
          cnt_q <= cnt_inc_c;
          if (puf_done) begin
`ifdef PUF_AUTH_MAJORITY_EN
            if (enroll_q && (run_q != 2'd2)) begin
              if (run_q == 2'd0) begin
                m0_q <= cap_c;
              end else begin
                m1_q <= cap_c;
              end
              run_q         <= run_q + 2'd1;
              puf_challenge <= issue_chal_c;
              parity_q      <= ~parity_q;
              state_q       <= ST_ISSUE;
            end else begin
              meas_q  <= enroll_q ? ((m0_q & m1_q) | (m0_q & cap_c) | (m1_q & cap_c)) : cap_c;
              state_q <= ST_EVAL;
            end
`else
            meas_q  <= cap_c;
            state_q <= ST_EVAL;
`endif
          end else if (cnt_q >= TO_LIM) begin
            result_valid <= 1'b1;
            timeout      <= 1'b1;
            pass         <= 1'b0;
            hdist        <= '0;
            state_q      <= ST_REPORT;
          end
        end
        ST_EVAL: begin
          result_valid <= 1'b1;
          timeout      <= 1'b0;
          if (enroll_q) begin
            pass  <= 1'b1;
            hdist <= '0;
          end else if (!mem_rvalid_c) begin
            pass  <= 1'b0;
            hdist <= 3'd7;
          end else begin
            pass  <= (32'(hd_c) <= THRESHOLD);
            hdist <= hd_c;
          end
          state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
